// File: rtl/lsu_mc_pkg.sv
// Shared definitions for the multi-cycle load/store unit: funct3 codes,
// FSM state encoding and size/legality decode helpers.
// Imported by lsu_align and lsu_mc.
package lsu_mc_pkg;

    // RV funct3 access codes (loads and stores share the low encodings)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // funct3[1:0] encodes log2 of the access size in bytes
    function automatic logic [3:0] f3_size(input logic [1:0] code);
        case (code)
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic f3_legal(input logic store, input logic [2:0] f3, input logic is64);
        logic ok;
        ok = 1'b0;
        if (store) begin
            case (f3)
                F3_B, F3_H, F3_W: ok = 1'b1;
                F3_D:             ok = is64;
                default:          ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
                F3_D, F3_WU:                    ok = is64;
                default:                        ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for lsu_mc: store lane shift / byte enables per beat,
// load merge of two beats plus sign/zero extension. Purely combinational.
// Ports: funct3/offset/beat select in, store data and two captured read beats in;
// per-beat be/wdata, split flag and extended load data out.
module lsu_align import lsu_mc_pkg::*; #(
    parameter int XLEN = 32
) (
    input  logic [2:0]                  funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]   off_i,
    input  logic                        beat1_i,
    input  logic [XLEN-1:0]             wdata_i,
    input  logic [XLEN-1:0]             rd0_i,
    input  logic [XLEN-1:0]             rd1_i,
    output logic [XLEN/8-1:0]           be_o,
    output logic [XLEN-1:0]             wdata_o,
    output logic                        split_o,
    output logic [XLEN-1:0]             ldata_o
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    logic [3:0]        sz;
    logic [OW+3:0]     bit_sh;
    logic [2*NB-1:0]   mask;
    logic [2*NB-1:0]   be_wide;
    logic [2*XLEN-1:0] wd_wide;
    logic [2*XLEN-1:0] rd_cat;
    logic [XLEN-1:0]   raw;
    logic              msb;
    logic              sgn;

    // Work in a two-beat window: lanes that spill past NB belong to beat 1.
    always_comb begin
        sz      = f3_size(funct3_i[1:0]);
        bit_sh  = {1'b0, off_i, 3'b000};
        mask    = '0;
        for (int i = 0; i < 2*NB; i++) begin
            mask[i] = (i < int'(sz));
        end
        be_wide = mask << off_i;
        wd_wide = {{XLEN{1'b0}}, wdata_i} << bit_sh;
        split_o = |be_wide[2*NB-1:NB];
        be_o    = beat1_i ? be_wide[2*NB-1:NB]       : be_wide[NB-1:0];
        wdata_o = beat1_i ? wd_wide[2*XLEN-1:XLEN]   : wd_wide[XLEN-1:0];

        // Beat 1 bytes sit directly above beat 0; shift the access down to bit 0.
        rd_cat  = {rd1_i, rd0_i};
        raw     = rd_cat[bit_sh +: XLEN];

        case (funct3_i[1:0])
            2'b00:   msb = raw[7];
            2'b01:   msb = raw[15];
            2'b10:   msb = raw[31];
            default: msb = 1'b0;
        endcase
        sgn     = msb & ~funct3_i[2];
        ldata_o = '0;
        for (int i = 0; i < XLEN; i++) begin
            ldata_o[i] = (i < 8*int'(sz)) ? raw[i] : sgn;
        end
    end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: valid/ready core request in, stalling bus out,
// one or two bus beats per access, one-cycle response pulse.
// Ports: clock/reset; req_* from core; rsp_* pulse to core; bus_* toward memory.
module lsu_mc import lsu_mc_pkg::*; #(
    parameter int XLEN             = 32,
    parameter int ADDR_W           = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_store,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_fault,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic [XLEN-1:0]     bus_rdata
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    lsu_state_e        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   rd0_q, rd0_d;
    logic [XLEN-1:0]   rd1_q, rd1_d;

    logic [3:0]        req_sz;
    logic              req_split;
    logic              req_fault;
    logic [ADDR_W-1:0] beat_base;
    logic [NB-1:0]     al_be;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_ldata;
    logic              al_split;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i (f3_q),
        .off_i    (addr_q[OW-1:0]),
        .beat1_i  (state_q == ST_BEAT1),
        .wdata_i  (wdata_q),
        .rd0_i    (rd0_q),
        .rd1_i    (rd1_q),
        .be_o     (al_be),
        .wdata_o  (al_wdata),
        .split_o  (al_split),
        .ldata_o  (al_ldata)
    );

    // Fault is decided on the incoming request so a faulting access never touches the bus.
    always_comb begin
        req_sz    = f3_size(req_funct3[1:0]);
        req_split = (int'(req_addr[OW-1:0]) + int'(req_sz)) > NB;
        req_fault = !f3_legal(req_store, req_funct3, XLEN == 64) ||
                    (req_split && !ALLOW_MISALIGNED);
    end

    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        fault_d   = fault_q;
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        bus_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    store_d = req_store;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    fault_d = req_fault;
                    state_d = req_fault ? ST_RESP : ST_BEAT0;
                end
            end
            ST_BEAT0: begin
                bus_valid = 1'b1;
                if (bus_ready) begin
                    rd0_d   = bus_rdata;
                    state_d = al_split ? ST_BEAT1 : ST_RESP;
                end
            end
            ST_BEAT1: begin
                bus_valid = 1'b1;
                if (bus_ready) begin
                    rd1_d   = bus_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus fields derive only from latched request state, so they stay put across wait states.
    assign beat_base = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};
    assign bus_we    = bus_valid & store_q;
    assign bus_addr  = !bus_valid ? '0 :
                       (state_q == ST_BEAT1) ? beat_base + ADDR_W'(NB) : beat_base;
    assign bus_be    = bus_valid ? al_be : '0;
    assign bus_wdata = bus_we ? al_wdata : '0;
    assign rsp_fault = rsp_valid & fault_q;
    assign rsp_rdata = (rsp_valid && !store_q && !fault_q) ? al_ldata : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            store_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

endmodule

// File: doc/lsu_mc.md
Name: lsu_mc

Overview:
Multi-cycle load/store unit for the RV core. It replaces the core's single-cycle, word-only memory path with a valid/ready request interface toward the core and a stalling bus interface toward memory. The unit handles byte, halfword, word and, when XLEN=64, doubleword accesses, with byte enables, sign/zero extension, wait states and optional split of misaligned accesses into two bus beats. It sits between the core's execute stage and the data bus.

Parameters:
XLEN, 32, data width; legal values are 32 and 64. NB = XLEN/8 bytes per beat.
ADDR_W, 32, byte address width.
ALLOW_MISALIGNED, 1, 1 = split boundary-crossing accesses into two beats; 0 = fault without bus access.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  core request valid
req_ready  out  1  unit can accept a request
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RV funct3 giving access size and signedness
req_addr  in  ADDR_W  byte address
req_wdata  in  XLEN  store data, LSB-aligned
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  XLEN  extended load data; 0 for stores and faults
rsp_fault  out  1  misaligned (ALLOW_MISALIGNED=0) or illegal funct3
bus_valid  out  1  bus request
bus_ready  in  1  bus accepts or completes the beat this cycle
bus_we  out  1  write
bus_addr  out  ADDR_W  NB-aligned beat address
bus_be  out  NB  byte enables
bus_wdata  out  XLEN  lane-shifted write data
bus_rdata  in  XLEN  read data, valid in the cycle bus_valid && bus_ready

Behaviour:
- Reset, asynchronous while reset=0: state IDLE. All outputs 0 except req_ready=1. A reset during a beat drops bus_valid immediately and discards the request.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready=1. Accept when req_valid && req_ready and latch all request fields.
  - Legal request → BEAT0.
  - Fault → RESP with rsp_fault=1 and no bus activity.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. XLEN=64 adds 011 LD and 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW. XLEN=64 adds 011 SD.
  - Any other code faults.
- Size: sz = 1, 2, 4 or 8 bytes; off = addr mod NB.
  - Access is misaligned when off + sz > NB.
  - Naturally misaligned accesses that fit inside one beat (e.g. LH at offset 1 on XLEN=32) take one beat.
- BEAT0: bus_addr = addr with the low log2(NB) bits cleared.
  - bus_be = ((1<<sz)-1) << off, truncated to NB bits.
  - bus_wdata = wdata << 8*off.
  - On bus_ready: capture the shifted bus_rdata, then go to BEAT1 if split, else RESP.
- BEAT1: bus_addr = BEAT0 address + NB, wrapping modulo 2^ADDR_W.
  - bus_be = the remaining low lanes.
  - bus_wdata = upper store bytes, LSB-aligned.
  - On bus_ready: merge the read bytes above the BEAT0 bytes, then go to RESP.
- While bus_valid && !bus_ready, bus_addr, bus_be, bus_we and bus_wdata hold stable. No timeout.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE.
  - Loads: rsp_rdata is sign-extended (LB, LH, LW on 64) or zero-extended (LBU, LHU, LWU).
  - Stores and faults: rsp_rdata=0.
- Latency with zero wait states: accept at N, BEAT0 at N+1, RESP at N+2; split accesses add 1 cycle; faults respond at N+1.
- Back-to-back: a new request is accepted the cycle after RESP. No overlap or pipelining.
- bus_valid=0 in IDLE and RESP.

Decomposition:
- Shared defines header holds:
  - funct3 load/store codes
  - state encodings
  - size-decode helper constants
- One combinational sub-module, lsu_align (parametrised on XLEN):
  - byte-lane shift, enable generation and split masks for stores
  - merge and sign/zero extension for loads
- The FSM and registers stay in lsu_mc.

Test Plan:
- XLEN=32, LW at 0x100, bus_rdata=0xDEADBEEF, bus_ready=1 → N+1: bus_addr=0x100, be=1111; N+2: rsp_valid, rdata=0xDEADBEEF.
- LB at 0x103, rdata=0x80123456 → be=1000, rsp_rdata=0xFFFFFF80. Same access with LBU → 0x00000080.
- SW at 0x102, wdata=0x11223344, ALLOW_MISALIGNED=1 → beat0: 0x100, be=1100, wdata=0x33440000; beat1: 0x104, be=0011, wdata=0x00001122; one rsp_valid.
- LW at 0xFFFFFFFE, beat0 rdata=0xAABB0000, beat1 rdata=0x0000CCDD → beat1 bus_addr=0x00000000, rsp_rdata=0xCCDDAABB.
- bus_ready held 0 for 3 cycles during an SH → bus signals stable, req_ready=0, rsp at the 4th cycle + 1.
- ALLOW_MISALIGNED=0, LH at 0x103 → no bus_valid, rsp_fault=1 at N+1. Separately, reset asserted mid-BEAT0 → bus_valid=0 immediately, req_ready=1 after release.
